counter_run_controller: RTL and testbench

- Sequencing controller for the 4-bit up counter datapath, running on the 50 MHz board clock.
- Generates a prescaled count-enable tick and steps the 4-bit count from 0 to a programmable limit.
- Limit behaviour is one-shot or auto-reload.
- Provides start/stop(pause)/clear control plus busy and done status for a higher-level FSM or button/debounce front end.

---
 rtl/counter_run_controller.sv | 110 +++++++++++
 tb/tb_counter_run_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_run_controller.sv
// Run controller for a 4-bit up counter: prescaled tick, start/pause/clear
// sequencing, one-shot or auto-reload limit handling, busy/done status.
module counter_run_controller #(
  parameter int unsigned DIV     = 50000000,
  parameter int unsigned PRESC_W = 26
) (
  input  logic       clk_50M,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Clear,
  input  logic [3:0] Limit,
  input  logic       Auto,
  output logic [3:0] Output,
  output logic       Busy,
  output logic       Done,
  output logic       Tick
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(DIV - 1);

  state_t               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [3:0]           lim_q, lim_d;
  logic [3:0]           cnt_d;
  logic [3:0]           step;
  logic                 done_d, tick_d;

  always_ff @(posedge clk_50M or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      lim_q   <= '0;
      Output  <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Tick    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      lim_q   <= lim_d;
      Output  <= cnt_d;
      Busy    <= (state_d == S_RUN) || (state_d == S_PAUSE);
      Done    <= done_d;
      Tick    <= tick_d;
    end
  end

  // Auto mode reloads to 0 after reaching the limit; one-shot never gets past it.
  always_comb begin
    step = Output + 4'd1;
    if (Auto && (Output == lim_q))
      step = '0;
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    lim_d   = lim_q;
    cnt_d   = Output;
    done_d  = 1'b0;
    tick_d  = 1'b0;
    if (Clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            lim_d   = Limit;
            cnt_d   = '0;
            presc_d = '0;
            if ((Limit == 4'd0) && !Auto) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_PAUSE: begin
          if (Start)
            state_d = S_RUN;
        end
        S_RUN: begin
          // Stop outranks a tick falling due in the same cycle.
          if (Stop) begin
            state_d = S_PAUSE;
          end else if (presc_q == PRESC_TOP) begin
            presc_d = '0;
            tick_d  = 1'b1;
            cnt_d   = step;
            if (step == lim_q) begin
              done_d = 1'b1;
              if (!Auto)
                state_d = S_DONE;
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_run_controller.sv
// Scoreboard bench for counter_run_controller (DIV=4): expected Tick/Done
// events are queued by the stimulus and checked by a decoupled monitor.
module tb_counter_run_controller;

  logic       clk_50M;
  logic       Reset;
  logic       Start;
  logic       Stop;
  logic       Clear;
  logic [3:0] Limit;
  logic       Auto;
  logic [3:0] Output;
  logic       Busy;
  logic       Done;
  logic       Tick;

  typedef struct {
    logic [3:0] out;
    logic       tick;
    logic       done;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   tests;
  int   failed;
  int   cyc_cnt;
  int   s;

  counter_run_controller #(.DIV(4), .PRESC_W(3)) dut (
    .clk_50M (clk_50M),
    .Reset   (Reset),
    .Start   (Start),
    .Stop    (Stop),
    .Clear   (Clear),
    .Limit   (Limit),
    .Auto    (Auto),
    .Output  (Output),
    .Busy    (Busy),
    .Done    (Done),
    .Tick    (Tick)
  );

  initial begin
    clk_50M = 1'b0;
    forever #5 clk_50M = ~clk_50M;
  end

  always @(posedge clk_50M) cyc_cnt <= cyc_cnt + 1;

  task automatic expect_ev(input logic [3:0] o, input logic t, input logic d, input int c);
    exp_t e;
    e.out  = o;
    e.tick = t;
    e.done = d;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_50M);
      if (Tick || Done) begin
        tests++;
        if (q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_pulse: got out=%0d tick=%0b done=%0b at cycle %0d, expected no pulse",
                   Output, Tick, Done, cyc_cnt);
        end else begin
          e = q.pop_front();
          if (Output !== e.out || Tick !== e.tick || Done !== e.done || cyc_cnt != e.cyc) begin
            failed++;
            $display("FAIL event: got out=%0d tick=%0b done=%0b cycle=%0d, expected out=%0d tick=%0b done=%0b cycle=%0d",
                     Output, Tick, Done, cyc_cnt, e.out, e.tick, e.done, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc_cnt < c) begin
      @(posedge clk_50M);
      #1;
    end
  endtask

  task automatic start_pulse(output int sc);
    Start = 1'b1;
    @(posedge clk_50M);
    #1;
    sc    = cyc_cnt;
    Start = 1'b0;
  endtask

  task automatic pulse_clear();
    Clear = 1'b1;
    @(posedge clk_50M);
    #1;
    Clear = 1'b0;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    Reset  = 1'b0;
    Start  = 1'b0;
    Stop   = 1'b0;
    Clear  = 1'b0;
    Limit  = 4'd0;
    Auto   = 1'b0;
    fork
      monitor();
    join_none

    #2;
    chk("reset_output", int'(Output), 0);
    chk("reset_busy_done_tick", int'({Busy, Done, Tick}), 0);
    @(posedge clk_50M);
    @(posedge clk_50M);
    #1;
    Reset = 1'b1;
    wait_to(cyc_cnt + 2);

    // One-shot to 3
    Limit = 4'd3; Auto = 1'b0;
    start_pulse(s);
    expect_ev(4'd1, 1'b1, 1'b0, s + 4);
    expect_ev(4'd2, 1'b1, 1'b0, s + 8);
    expect_ev(4'd3, 1'b1, 1'b1, s + 12);
    chk("oneshot_busy_after_start", int'(Busy), 1);
    wait_to(s + 11);
    chk("oneshot_busy_before_done", int'(Busy), 1);
    wait_to(s + 12);
    chk("oneshot_busy_at_done", int'(Busy), 0);
    wait_to(s + 20);
    chk("oneshot_hold_output", int'(Output), 3);

    // Auto-reload to 2 (started from DONE)
    Limit = 4'd2; Auto = 1'b1;
    start_pulse(s);
    chk("auto_restart_output", int'(Output), 0);
    for (int k = 1; k <= 6; k++)
      expect_ev(4'(k % 3), 1'b1, (k % 3) == 2, s + 4 * k);
    wait_to(s + 24);
    chk("auto_busy", int'(Busy), 1);
    pulse_clear();
    chk("auto_clear_output", int'(Output), 0);
    chk("auto_clear_busy", int'(Busy), 0);

    // Pause on the tick cycle, then resume with preserved phase
    Limit = 4'd5; Auto = 1'b0;
    start_pulse(s);
    expect_ev(4'd1, 1'b1, 1'b0, s + 4);
    wait_to(s + 7);
    Stop = 1'b1;
    @(posedge clk_50M);
    #1;
    Stop = 1'b0;
    chk("pause_output", int'(Output), 1);
    chk("pause_busy", int'(Busy), 1);
    wait_to(s + 18);
    chk("pause_hold_output", int'(Output), 1);
    start_pulse(s);
    expect_ev(4'd2, 1'b1, 1'b0, s + 1);
    expect_ev(4'd3, 1'b1, 1'b0, s + 5);
    expect_ev(4'd4, 1'b1, 1'b0, s + 9);
    expect_ev(4'd5, 1'b1, 1'b1, s + 13);
    wait_to(s + 14);
    chk("resume_final_output", int'(Output), 5);
    chk("resume_final_busy", int'(Busy), 0);

    // Clear mid-run, Clear+Start together, Start while running
    start_pulse(s);
    expect_ev(4'd1, 1'b1, 1'b0, s + 4);
    expect_ev(4'd2, 1'b1, 1'b0, s + 8);
    wait_to(s + 8);
    pulse_clear();
    chk("clear_run_output", int'(Output), 0);
    chk("clear_run_busy", int'(Busy), 0);
    Clear = 1'b1; Start = 1'b1;
    @(posedge clk_50M);
    #1;
    Clear = 1'b0; Start = 1'b0;
    chk("clear_wins_busy", int'(Busy), 0);
    wait_to(cyc_cnt + 6);
    chk("clear_wins_output", int'(Output), 0);
    Limit = 4'd2; Auto = 1'b0;
    start_pulse(s);
    expect_ev(4'd1, 1'b1, 1'b0, s + 4);
    expect_ev(4'd2, 1'b1, 1'b1, s + 8);
    wait_to(s + 2);
    Limit = 4'd7;
    Start = 1'b1;
    @(posedge clk_50M);
    #1;
    Start = 1'b0;
    wait_to(s + 9);
    chk("start_in_run_output", int'(Output), 2);
    chk("start_in_run_busy", int'(Busy), 0);

    // Limit 0 one-shot: immediate DONE
    Limit = 4'd0; Auto = 1'b0;
    start_pulse(s);
    expect_ev(4'd0, 1'b0, 1'b1, s);
    chk("limit0_busy", int'(Busy), 0);
    wait_to(s + 8);
    chk("limit0_output", int'(Output), 0);

    // Limit 15 auto: full range with 15 -> 0 wrap
    Limit = 4'd15; Auto = 1'b1;
    start_pulse(s);
    for (int k = 1; k <= 16; k++)
      expect_ev(4'(k), 1'b1, k == 15, s + 4 * k);
    wait_to(s + 64);
    pulse_clear();

    // Asynchronous reset mid-count
    Limit = 4'd5; Auto = 1'b0;
    start_pulse(s);
    expect_ev(4'd1, 1'b1, 1'b0, s + 4);
    expect_ev(4'd2, 1'b1, 1'b0, s + 8);
    expect_ev(4'd3, 1'b1, 1'b0, s + 12);
    wait_to(s + 13);
    chk("pre_reset_output", int'(Output), 3);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_reset_output", int'(Output), 0);
    chk("async_reset_busy", int'(Busy), 0);
    @(posedge clk_50M);
    @(posedge clk_50M);
    #1;
    Reset = 1'b1;
    wait_to(cyc_cnt + 10);
    chk("post_reset_output", int'(Output), 0);
    chk("post_reset_busy", int'(Busy), 0);

    for (int i = 0; i < 20 && q.size() != 0; i++)
      @(posedge clk_50M);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      failed++;
      $display("FAIL missing_event: got none, expected out=%0d tick=%0b done=%0b cycle=%0d",
               e.out, e.tick, e.done, e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
